// File: rtl/cache_control.sv
// cache_control: direct-mapped cache controller for the LC-3b memory path.
//
// Holds the tag, valid and dirty bits for every set. The line data lives in an
// external 8-entry x 256-bit array that this block indexes and writes. CPU
// loads and stores are 16-bit. Misses write back a dirty victim to physical
// memory first if needed, then fill the line.
//
// Ports
//   clk, rst_n            clock; synchronous active-low reset
//   mem_read/mem_write    CPU request, held until mem_resp
//   mem_byte_enable       store byte lanes ([0] low byte, [1] high byte)
//   mem_address           byte address: tag [15:8], index [7:5], offset [4:0]
//   mem_wdata/mem_rdata   store / load data
//   mem_resp              one-cycle completion pulse
//   array_index/_write    data array index and write enable
//   array_datain/_dataout data array write line / combinational read line
//   pmem_read/_write      physical memory fill / write-back request
//   pmem_address          line-aligned physical address
//   pmem_wdata/_rdata     write-back line / fill line
//   pmem_resp             physical memory completion pulse
module cache_control #(
  parameter int unsigned NUM_SETS   = 8,
  parameter int unsigned LINE_WIDTH = 256,
  parameter int unsigned TAG_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [1:0]            mem_byte_enable,
  input  logic [15:0]           mem_address,
  input  logic [15:0]           mem_wdata,
  output logic [15:0]           mem_rdata,
  output logic                  mem_resp,
  output logic [2:0]            array_index,
  output logic                  array_write,
  output logic [LINE_WIDTH-1:0] array_datain,
  input  logic [LINE_WIDTH-1:0] array_dataout,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [15:0]           pmem_address,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic [LINE_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp
);

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    ALLOCATE
  } state_e;

  state_e                 state_q, state_d;
  logic [NUM_SETS-1:0]    valid_q, valid_d;
  logic [NUM_SETS-1:0]    dirty_q, dirty_d;
  logic [TAG_WIDTH-1:0]   tag_q [NUM_SETS];
  logic [TAG_WIDTH-1:0]   tag_d [NUM_SETS];

  logic [2:0]             idx;
  logic [TAG_WIDTH-1:0]   addr_tag;
  logic [3:0]             word;
  logic [7:0]             bit_base;
  logic                   hit;
  logic                   req;
  logic [15:0]            rd_word;
  logic [LINE_WIDTH-1:0]  merged;

  // The byte-offset LSB is not needed: accesses are whole 16-bit words.
  logic                   unused_addr_lsb;
  assign unused_addr_lsb = mem_address[0];

  assign idx         = mem_address[7:5];
  assign addr_tag    = mem_address[15:8];
  assign word        = mem_address[4:1];
  assign bit_base    = {word, 4'b0000};
  assign array_index = idx;
  assign req         = mem_read | mem_write;
  assign hit         = valid_q[idx] && (tag_q[idx] == addr_tag);
  assign rd_word     = array_dataout[bit_base +: 16];

  // Store merge: only the enabled bytes of the addressed word change.
  always_comb begin
    merged = array_dataout;
    if (mem_byte_enable[0]) merged[bit_base +: 8]          = mem_wdata[7:0];
    if (mem_byte_enable[1]) merged[bit_base + 8'd8 +: 8]   = mem_wdata[15:8];
  end

  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    dirty_d      = dirty_q;
    tag_d        = tag_q;
    mem_resp     = 1'b0;
    mem_rdata    = '0;
    array_write  = 1'b0;
    array_datain = '0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;

    unique case (state_q)
      IDLE: begin
        if (req) begin
          if (hit) begin
            mem_resp  = 1'b1;
            mem_rdata = rd_word;
            // A simultaneous read and write is served as a write.
            if (mem_write) begin
              array_write  = 1'b1;
              array_datain = merged;
              dirty_d[idx] = 1'b1;
            end
          end else begin
            state_d = dirty_q[idx] ? WRITEBACK : ALLOCATE;
          end
        end
      end

      WRITEBACK: begin
        pmem_write   = 1'b1;
        pmem_address = {tag_q[idx], idx, 5'b00000};
        pmem_wdata   = array_dataout;
        if (pmem_resp) begin
          dirty_d[idx] = 1'b0;
          state_d      = ALLOCATE;
        end
      end

      ALLOCATE: begin
        pmem_read    = 1'b1;
        pmem_address = {mem_address[15:5], 5'b00000};
        if (pmem_resp) begin
          array_write  = 1'b1;
          array_datain = pmem_rdata;
          tag_d[idx]   = addr_tag;
          valid_d[idx] = 1'b1;
          dirty_d[idx] = 1'b0;
          state_d      = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      valid_q <= '0;
      dirty_q <= '0;
      for (int unsigned i = 0; i < NUM_SETS; i++) tag_q[i] <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      dirty_q <= dirty_d;
      tag_q   <= tag_d;
    end
  end

endmodule
